tile_gather_4x4: RTL and testbench
==================================

TILE_GATHER_4X4 -- requirements
Module: tile_gather_4x4

Interface
REQ-001 Parameter IMG_W, default 8: image width in pixels; SHALL be a multiple of 4 and at least 4.
REQ-002 Parameter IMG_H, default 8: image height in pixels; SHALL be a multiple of 4 and at least 4.
REQ-003 clk  in  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  in  1  reset, asynchronous and active-low.
REQ-005 in_valid  in  1  in_pix carries a valid pixel.
REQ-006 in_pix  in  8  unsigned pixel, raster order (row-major across the whole frame).
REQ-007 in_ready  out  1  block accepts in_pix this cycle.
REQ-008 out_valid  out  1  out_tile holds a valid 4x4 tile.
REQ-009 out_tile  out  128  tile, element (r,c) at bits [127-8*(4r+c) -: 8]; this is the layout the downstream avg_pool2d data_in_flat input consumes.
REQ-010 out_ready  in  1  downstream accepts out_tile this cycle.
REQ-011 out_last  out  1  current tile is the last tile of the frame; valid only with out_valid.

Function
REQ-012 A pixel transfer SHALL occur on a cycle where in_valid and in_ready are both high; a tile transfer SHALL occur on a cycle where out_valid and out_ready are both high.
REQ-013 The FSM SHALL have two states. FILL: in_ready=1, out_valid=0. DRAIN: in_ready=0, out_valid=1.
REQ-014 In FILL, each accepted pixel SHALL be written to band buffer row band_row, column col. col SHALL wrap IMG_W-1 to 0. band_row SHALL increment on that wrap, wrapping 3 to 0.
REQ-015 When the pixel at band_row=3, col=IMG_W-1 is accepted, the FSM SHALL enter DRAIN on the next edge, with tile index t=0. out_valid SHALL be high exactly one cycle after that accept.
REQ-016 In DRAIN, out_tile SHALL present buffer columns 4t..4t+3 of rows 0..3.
REQ-017 On each tile transfer, t SHALL increment. On the transfer with t=IMG_W/4-1, the FSM SHALL return to FILL, and in_ready SHALL be high on the next cycle.
REQ-018 out_tile and out_valid SHALL hold stable while out_valid=1 and out_ready=0.
REQ-019 With out_ready held high, the block SHALL deliver one tile per cycle.
REQ-020 A band counter SHALL count 0..IMG_H/4-1. It SHALL increment on return to FILL, wrapping to 0 after the final band.
REQ-021 out_last SHALL be 1 iff out_valid=1, band = IMG_H/4-1 and t = IMG_W/4-1.
REQ-022 When out_valid=0, out_tile SHALL be driven as 0.
REQ-023 in_pix SHALL be ignored whenever in_ready=0; no pixel is lost or duplicated across state changes.
REQ-024 All arithmetic is on unsigned counters sized to $clog2 of their range; no pixel value is modified.

Reset
REQ-025 Asserting rst_n=0 SHALL immediately force: FILL state, col=0, band_row=0, t=0, band=0, out_valid=0, out_last=0, out_tile=0, in_ready=1 (reads 1 during reset).
REQ-026 Reset during FILL or DRAIN SHALL discard the partial band; the next accepted pixel after release is frame pixel (0,0).
REQ-027 Band buffer contents need not be reset.

Structure
REQ-028 Package pool_pkg SHALL hold PIX_W=8, TILE_DIM=4 and TILE_BITS=128, shared with avg_pool2d users.
REQ-029 Storage SHALL be in sub-module tile_band_buffer: 4 x IMG_W x 8-bit registers with a write port (row, col, data) and a read port (tile index -> 128-bit tile).
REQ-030 The FSM and counters SHALL reside in tile_gather_4x4.

Verification (IMG_W=8, IMG_H=8; pixel value = raster index mod 256)
REQ-031 Assert rst_n=0 mid-clock -> out_valid=0, out_tile=0, in_ready=1, with no clock edge needed.
REQ-032 Stream pixels 0..31 back-to-back -> out_valid rises the cycle after pixel 31 is accepted.
- Tile 0 = 0x00010203_08090A0B_10111213_18191A1B.
- Tile 1 = 0x04050607_0C0D0E0F_14151617_1C1D1E1F.
- in_ready=0 throughout both tiles.
REQ-033 Hold out_ready=0 for 5 cycles while tile 0 is presented -> out_tile and out_valid stay unchanged; both tiles then arrive in order.
REQ-034 Send a full 64-pixel frame with out_ready=1 -> 4 tiles, out_last=1 only on the 4th (0x24252627_2C2D2E2F_34353637_3C3D3E3F); the next frame restarts at band 0.
REQ-035 Toggle in_valid randomly during FILL -> tiles are identical to the gap-free case.
REQ-036 Assert reset after tile 0 of band 0 is transferred, then send pixels 100..131 -> first tile = 0x64656667_6C6D6E6F_74757677_7C7D7E7F.

Source files
------------

// File: rtl/pool_pkg.sv
// Shared pixel/tile geometry for the 4x4 tiling and pooling blocks.
package pool_pkg;

  localparam int PIX_W     = 8;
  localparam int TILE_DIM  = 4;
  localparam int TILE_BITS = PIX_W * TILE_DIM * TILE_DIM;

  typedef enum logic {
    ST_FILL  = 1'b0,
    ST_DRAIN = 1'b1
  } gather_state_e;

  // Counter width for a range of n values; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tile_band_buffer.sv
// One band of the image (4 rows x IMG_W pixels) with a pixel write port and
// a 4x4 tile read port; element (r,c) of the tile sits at the MSB end first.
module tile_band_buffer
  import pool_pkg::*;
#(
  parameter int IMG_W = 8,
  localparam int COL_W  = cnt_width(IMG_W),
  localparam int TIDX_W = cnt_width(IMG_W / TILE_DIM)
) (
  input  logic                 clk,
  input  logic                 wr_en_i,
  input  logic [1:0]           wr_row_i,
  input  logic [COL_W-1:0]     wr_col_i,
  input  logic [PIX_W-1:0]     wr_data_i,
  input  logic [TIDX_W-1:0]    rd_tile_i,
  output logic [TILE_BITS-1:0] rd_tile_o
);

  logic [PIX_W-1:0] mem_q [TILE_DIM][IMG_W];

  // Storage is deliberately left without reset: every cell is rewritten
  // before it is read for the next band.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_row_i][wr_col_i] <= wr_data_i;
    end
  end

  always_comb begin
    logic [COL_W-1:0] base;
    base      = COL_W'({rd_tile_i, 2'b00});
    rd_tile_o = '0;
    for (int r = 0; r < TILE_DIM; r++) begin
      for (int c = 0; c < TILE_DIM; c++) begin
        rd_tile_o[TILE_BITS-1-PIX_W*(TILE_DIM*r+c) -: PIX_W] = mem_q[r][base + COL_W'(c)];
      end
    end
  end

endmodule

// File: rtl/tile_gather_4x4.sv
// Gathers a raster pixel stream into 4-row bands and emits each band as
// IMG_W/4 tiles of 4x4 pixels, flagging the last tile of the frame.
module tile_gather_4x4
  import pool_pkg::*;
#(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic [PIX_W-1:0]     in_pix,
  output logic                 in_ready,
  output logic                 out_valid,
  output logic [TILE_BITS-1:0] out_tile,
  input  logic                 out_ready,
  output logic                 out_last,
  output gather_state_e        dbg_state_o
);

  localparam int COL_W  = cnt_width(IMG_W);
  localparam int TIDX_W = cnt_width(IMG_W / TILE_DIM);
  localparam int BAND_W = cnt_width(IMG_H / TILE_DIM);

  localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(IMG_W - 1);
  localparam logic [TIDX_W-1:0] LAST_T    = TIDX_W'(IMG_W / TILE_DIM - 1);
  localparam logic [BAND_W-1:0] LAST_BAND = BAND_W'(IMG_H / TILE_DIM - 1);

  gather_state_e     state_q, state_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [1:0]        band_row_q, band_row_d;
  logic [TIDX_W-1:0] t_q, t_d;
  logic [BAND_W-1:0] band_q, band_d;

  logic                 pix_accept;
  logic                 tile_xfer;
  logic [TILE_BITS-1:0] buf_tile;

  // Handshake: a transfer happens on any cycle where valid and ready are both
  // high; ready depends only on state, never on the partner's valid.
  assign in_ready   = (state_q == ST_FILL);
  assign out_valid  = (state_q == ST_DRAIN);
  assign pix_accept = in_valid && in_ready;
  assign tile_xfer  = out_valid && out_ready;

  assign out_tile    = out_valid ? buf_tile : '0;
  assign out_last    = out_valid && (band_q == LAST_BAND) && (t_q == LAST_T);
  assign dbg_state_o = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_FILL;
      col_q      <= '0;
      band_row_q <= '0;
      t_q        <= '0;
      band_q     <= '0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      band_row_q <= band_row_d;
      t_q        <= t_d;
      band_q     <= band_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    band_row_d = band_row_q;
    t_d        = t_q;
    band_d     = band_q;
    case (state_q)
      ST_FILL: begin
        if (pix_accept) begin
          if (col_q == LAST_COL) begin
            col_d      = '0;
            band_row_d = band_row_q + 2'd1;
            if (band_row_q == 2'd3) begin
              state_d = ST_DRAIN;
              t_d     = '0;
            end
          end else begin
            col_d = col_q + COL_W'(1);
          end
        end
      end
      ST_DRAIN: begin
        if (tile_xfer) begin
          if (t_q == LAST_T) begin
            state_d = ST_FILL;
            t_d     = '0;
            band_d  = (band_q == LAST_BAND) ? '0 : band_q + BAND_W'(1);
          end else begin
            t_d = t_q + TIDX_W'(1);
          end
        end
      end
      default: state_d = ST_FILL;
    endcase
  end

  tile_band_buffer #(
    .IMG_W(IMG_W)
  ) u_band (
    .clk      (clk),
    .wr_en_i  (pix_accept),
    .wr_row_i (band_row_q),
    .wr_col_i (col_q),
    .wr_data_i(in_pix),
    .rd_tile_i(t_q),
    .rd_tile_o(buf_tile)
  );

endmodule

// File: tb/tb_tile_gather_4x4.sv
// Directed-plus-random bench for tile_gather_4x4 on an 8x8 frame.
module tb_tile_gather_4x4;
  import pool_pkg::*;

  localparam int W  = 8;
  localparam int H  = 8;
  localparam int NT = W / 4;

  localparam logic [127:0] T0_REF  = 128'h00010203_08090A0B_10111213_18191A1B;
  localparam logic [127:0] T1_REF  = 128'h04050607_0C0D0E0F_14151617_1C1D1E1F;
  localparam logic [127:0] T3_REF  = 128'h24252627_2C2D2E2F_34353637_3C3D3E3F;
  localparam logic [127:0] T100_REF = 128'h64656667_6C6D6E6F_74757677_7C7D7E7F;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          in_valid = 1'b0;
  logic [7:0]    in_pix = '0;
  logic          in_ready;
  logic          out_valid;
  logic [127:0]  out_tile;
  logic          out_ready = 1'b0;
  logic          out_last;
  gather_state_e dbg_state;

  tile_gather_4x4 #(.IMG_W(W), .IMG_H(H)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_pix     (in_pix),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_tile   (out_tile),
    .out_ready  (out_ready),
    .out_last   (out_last),
    .dbg_state_o(dbg_state)
  );

  // scoreboard: {last, tile}
  int           checks = 0;
  int           failures = 0;
  int           acc_cnt = 0;
  logic [7:0]   band_pix [4][W];
  logic [128:0] exp_q[$];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
    end
  endtask

  // Reference tile: walk the tile row by row, appending pixels.
  function automatic logic [127:0] ref_tile(input int t);
    logic [127:0] acc;
    acc = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        acc = {acc[119:0], band_pix[r][4*t+c]};
    return acc;
  endfunction

  task automatic model_accept(input logic [7:0] v);
    int f, row, col;
    f   = acc_cnt % (W * H);
    row = f / W;
    col = f % W;
    band_pix[row % 4][col] = v;
    acc_cnt++;
    if (col == W - 1 && row % 4 == 3)
      for (int t = 0; t < NT; t++)
        exp_q.push_back({(row == H - 1) && (t == NT - 1), ref_tile(t)});
  endtask

  task automatic model_reset();
    acc_cnt = 0;
    exp_q.delete();
  endtask

  // driver tasks (entered and left at a falling edge)
  task automatic send_px(input logic [7:0] v);
    int n;
    in_valid = 1'b1;
    in_pix   = v;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      chk("in_ready_timeout", 128'(in_ready), 128'd1);
    end else begin
      @(posedge clk);
      model_accept(v);
      @(negedge clk);
    end
  endtask

  task automatic send_band(input int base, input bit gaps);
    for (int i = 0; i < 32; i++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
        in_pix   = 8'($urandom);
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
      send_px(8'(base + i));
    end
    in_valid = 1'b0;
  endtask

  task automatic recv_tile(input string tag, input int stall_max, output logic [127:0] got);
    int n;
    logic [128:0] e;
    got = '0;
    out_ready = 1'b0;
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      chk({tag, "_timeout"}, 128'(out_valid), 128'd1);
    end else if (exp_q.size() == 0) begin
      chk({tag, "_unexpected"}, 128'(exp_q.size()), 128'd1);
    end else begin
      e = exp_q.pop_front();
      repeat ($urandom_range(0, stall_max)) begin
        chk({tag, "_hold"}, out_tile, e[127:0]);
        @(negedge clk);
      end
      out_ready = 1'b1;
      got = out_tile;
      chk(tag, out_tile, e[127:0]);
      chk({tag, "_last"}, 128'(out_last), 128'(e[128]));
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
    end
  endtask

  task automatic mid_clock_reset(input string tag);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk({tag, "_out_valid"}, 128'(out_valid), 128'd0);
    chk({tag, "_out_tile"}, out_tile, 128'd0);
    chk({tag, "_in_ready"}, 128'(in_ready), 128'd1);
    chk({tag, "_out_last"}, 128'(out_last), 128'd0);
    model_reset();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] got;

    // reset values without any clock edge
    #1;
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_out_tile", out_tile, 128'd0);
    chk("rst_in_ready", 128'(in_ready), 128'd1);
    chk("rst_out_last", 128'(out_last), 128'd0);
    chk("rst_state", 128'(dbg_state), 128'(ST_FILL));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // band 0 back-to-back, downstream stalled on tile 0
    for (int i = 0; i < 31; i++) send_px(8'(i));
    chk("pre_fill_out_valid", 128'(out_valid), 128'd0);
    send_px(8'd31);
    in_valid = 1'b0;
    chk("fill_out_valid_rise", 128'(out_valid), 128'd1);
    chk("drain_in_ready", 128'(in_ready), 128'd0);
    chk("tile0_literal", out_tile, T0_REF);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("stall_tile0", out_tile, T0_REF);
      chk("stall_valid", 128'(out_valid), 128'd1);
      chk("stall_in_ready", 128'(in_ready), 128'd0);
    end
    out_ready = 1'b1;
    chk("tile0_model", out_tile, exp_q[0][127:0]);
    chk("tile0_last", 128'(out_last), 128'd0);
    void'(exp_q.pop_front());
    @(posedge clk);
    @(negedge clk);
    chk("tile1_back_to_back", 128'(out_valid), 128'd1);
    chk("tile1_literal", out_tile, T1_REF);
    chk("tile1_model", out_tile, exp_q[0][127:0]);
    chk("tile1_in_ready", 128'(in_ready), 128'd0);
    void'(exp_q.pop_front());
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("refill_in_ready", 128'(in_ready), 128'd1);
    chk("refill_out_valid", 128'(out_valid), 128'd0);
    chk("refill_out_tile", out_tile, 128'd0);

    // band 1 with input gaps, then the final tile of the frame
    send_band(32, 1'b1);
    recv_tile("f0b1_t0", 0, got);
    recv_tile("f0b1_t1", 0, got);
    chk("tile3_literal", got, T3_REF);

    // second frame: random gaps both sides
    send_band(64, 1'b1);
    recv_tile("f1b0_t0", 3, got);
    recv_tile("f1b0_t1", 3, got);
    send_band(96, 1'b1);
    recv_tile("f1b1_t0", 3, got);
    recv_tile("f1b1_t1", 3, got);

    // reset after tile 0 of band 0 went out
    send_band(200, 1'b0);
    recv_tile("f2b0_t0", 0, got);
    mid_clock_reset("rst_drain");
    send_band(100, 1'b0);
    recv_tile("post_rst_t0", 1, got);
    chk("post_rst_literal", got, T100_REF);
    recv_tile("post_rst_t1", 1, got);

    // reset in the middle of filling a band
    for (int i = 0; i < 10; i++) send_px(8'(i + 50));
    in_valid = 1'b0;
    mid_clock_reset("rst_fill");
    send_band(0, 1'b1);
    recv_tile("fill_rst_t0", 2, got);
    chk("fill_rst_literal", got, T0_REF);
    recv_tile("fill_rst_t1", 2, got);

    chk("exp_q_drained", 128'(exp_q.size()), 128'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
